// File: rtl/muldiv_ctrl_if.sv
// Purpose : EX-stage <-> multiply/divide sequencer bundle (request, operands, flush, result).
// Ports   : master = EX stage (drives start/op/operands/HI/LO/flush), slave = muldiv_ctrl.
// Signals : start_i, op_i, src_a_i, src_b_i, hi_i, lo_i, flush_i -> ; <- stall_o, done_o, result_o, whilo_o.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 start_i;
  logic [2:0]           op_i;
  logic [WIDTH-1:0]     src_a_i;
  logic [WIDTH-1:0]     src_b_i;
  logic [WIDTH-1:0]     hi_i;
  logic [WIDTH-1:0]     lo_i;
  logic                 flush_i;
  logic                 stall_o;
  logic                 done_o;
  logic [2*WIDTH-1:0]   result_o;
  logic [1:0]           whilo_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, hi_i, lo_i, flush_i,
    input  stall_o, done_o, result_o, whilo_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, hi_i, lo_i, flush_i,
    output stall_o, done_o, result_o, whilo_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Purpose : multi-cycle MULT/MULTU, DIV/DIVU, MADD/MADDU, MSUB/MSUBU sequencer producing {HI,LO}.
// Latency : MUL MUL_LAT cycles, accumulate MUL_LAT+1, divide 34 (2 for /0 or early-out), done_o pulses once.
// Backpr. : stall_o holds IF..EX while busy (and combinationally on start_i in IDLE); flush_i aborts.
// Ports   : clk, rst (sync, active high); bus (muldiv_ctrl_if.slave) carries request, operands and result.
// Option  : define MULDIV_EARLY_OUT_EN to skip the divide loop when |dividend| < |divisor|.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int WIDTH   = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ACC, S_DIV, S_FIX, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d, res_q, res_d;
  logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  // Request decode (only meaningful in IDLE)
  logic             idle, accept, in_sgn, in_div, in_bz, early_hit;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle && bus.start_i && !bus.flush_i;
  assign in_sgn = ~bus.op_i[0];
  assign in_div = (bus.op_i[2:1] == 2'b01);
  assign in_bz  = (bus.src_b_i == '0);
  assign a_mag  = (in_sgn && bus.src_a_i[WIDTH-1]) ? -bus.src_a_i : bus.src_a_i;
  assign b_mag  = (in_sgn && bus.src_b_i[WIDTH-1]) ? -bus.src_b_i : bus.src_b_i;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_hit = (a_mag < b_mag);
`else
  assign early_hit = 1'b0;
`endif

  // Multiplier: live inputs in IDLE (needed when MUL_LAT==1), latched copies afterwards.
  // 64x64 of the sign/zero-extended operands gives the exact 33x33 product mod 2^64.
  logic [2:0]         m_op;
  logic [WIDTH-1:0]   m_a, m_b;
  logic [2*WIDTH-1:0] m_ea, m_eb, prod;

  assign m_op = idle ? bus.op_i    : op_q;
  assign m_a  = idle ? bus.src_a_i : a_q;
  assign m_b  = idle ? bus.src_b_i : b_q;
  assign m_ea = {{WIDTH{~m_op[0] & m_a[WIDTH-1]}}, m_a};
  assign m_eb = {{WIDTH{~m_op[0] & m_b[WIDTH-1]}}, m_b};
  assign prod = m_ea * m_eb;

  // One restoring-division step: shift next dividend bit into the partial remainder.
  logic [WIDTH:0] div_sh, div_diff;
  logic           div_take;

  assign div_sh   = {rem_q, quo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, dvs_q};
  assign div_take = ~div_diff[WIDTH];

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hilo_q  <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hilo_q  <= hilo_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_div)              state_d = (in_bz || early_hit) ? S_FIX : S_DIV;
          else if (MUL_LAT == 1)   state_d = bus.op_i[2] ? S_ACC : S_DONE;
          else                     state_d = S_MUL;
        end
      end
      S_MUL:   if (cnt_q == '0) state_d = op_q[2] ? S_ACC : S_DONE;
      S_ACC:   state_d = S_DONE;
      S_DIV:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i) state_d = S_IDLE;
  end

  // Datapath next-state
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hilo_d = hilo_q;
    res_d  = res_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.op_i;
          a_d    = bus.src_a_i;
          b_d    = bus.src_b_i;
          hilo_d = {bus.hi_i, bus.lo_i};
          dz_d   = in_bz;
          qneg_d = in_sgn && (bus.src_a_i[WIDTH-1] ^ bus.src_b_i[WIDTH-1]);
          rneg_d = in_sgn && bus.src_a_i[WIDTH-1];
          dvs_d  = b_mag;
          // Early-out preloads the final magnitudes: quotient 0, remainder |a|.
          quo_d  = early_hit ? '0 : a_mag;
          rem_d  = early_hit ? a_mag : '0;
          if (in_div)           cnt_d = 6'(WIDTH - 1);
          else if (MUL_LAT > 1) cnt_d = 6'(MUL_LAT - 2);
          if (!in_div && MUL_LAT == 1) res_d = prod;
        end
      end
      S_MUL: begin
        if (cnt_q == '0) res_d = prod;
        else             cnt_d = cnt_q - 6'd1;
      end
      S_ACC: res_d = op_q[1] ? (hilo_q - res_q) : (hilo_q + res_q);
      S_DIV: begin
        rem_d = div_take ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], div_take};
        cnt_d = cnt_q - 6'd1;
      end
      S_FIX: begin
        if (dz_q) res_d = {a_q, {WIDTH{1'b1}}};
        else      res_d = {(rneg_q ? -rem_q : rem_q), (qneg_q ? -quo_q : quo_q)};
      end
      default: ;
    endcase
  end

  // Outputs
  logic       stall, done;
  logic [1:0] whilo;

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    whilo = 2'b00;
    case (state_q)
      S_IDLE:  stall = bus.start_i;
      S_DONE:  done  = ~bus.flush_i;
      default: stall = 1'b1;
    endcase
    if (done) whilo = 2'b11;
  end

  assign bus.stall_o  = stall;
  assign bus.done_o   = done;
  assign bus.whilo_o  = whilo;
  assign bus.result_o = res_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer in the EX stage. Owns the HI/LO-producing arithmetic: MULT/MULTU, DIV/DIVU, MADD/MADDU, MSUB/MSUBU.
Holds the pipeline via stall_o while a MUL, accumulate or 32-iteration restoring DIV runs. Returns the 64-bit {HI,LO} result with a one-cycle done pulse and a HI/LO write enable.
Cancelled by pipeline flush (exception/ERET).

Parameters:
MUL_LAT, 2, cycles from accepted start to done_o for MULT/MULTU (legal 1..4)
WIDTH, 32, operand width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  EX holds a mul/div/acc op (already qualified by decode)
op_i  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MADD 5=MADDU 6=MSUB 7=MSUBU
src_a_i  in  32  rs operand
src_b_i  in  32  rt operand
hi_i  in  32  current HI (accumulate base)
lo_i  in  32  current LO (accumulate base)
flush_i  in  1  pipeline flush; aborts operation
stall_o  out  1  hold IF..EX
done_o  out  1  result valid pulse
result_o  out  64  {HI,LO}
whilo_o  out  2  HI/LO write enable {hi,lo}; 2'b11 on done, else 2'b00

Behaviour:
- Reset: state IDLE; done_o=0, whilo_o=0, result_o=0, stall_o=0; all internal registers cleared.
- States: IDLE, MUL, ACC, DIV, FIX, DONE.
- IDLE:
  - start_i && !flush_i accepted in cycle t; op, operands, hi_i and lo_i are latched.
  - stall_o = start_i (combinational) in IDLE.
- MUL ops (0,1):
  - MUL for MUL_LAT-1 cycles, then DONE. done_o is asserted in cycle t+MUL_LAT.
  - Signed ops use 33-bit sign-extended operands; unsigned ops zero-extend.
- Accumulate ops (4-7):
  - MUL, then ACC for one cycle: result = {HI,LO} ± product, mod 2^64.
  - done_o at t+MUL_LAT+1.
- DIV ops (2,3):
  - Signed ops convert operands to magnitudes.
  - DIV runs 32 restoring iterations (cycles t+1..t+32).
  - FIX (t+33) negates the quotient if the operand signs differ and negates the remainder if the dividend is negative.
  - DONE at t+34. result_o = {remainder, quotient}.
- Divide by zero: skip DIV; FIX at t+1, DONE at t+2; result = {src_a, 32'hFFFFFFFF} for both signed and unsigned. No exception is raised.
- stall_o is 1 in every non-IDLE state except DONE. In DONE, stall_o=0, done_o=1 and whilo_o=2'b11 so the op retires and the pipeline advances that cycle. Next state is IDLE.
- A new start_i in DONE is ignored; it is re-sampled in IDLE the following cycle (the retiring op has left EX).
- flush_i in any state:
  - next state IDLE; done_o and whilo_o forced 0 in that cycle; no HI/LO write.
  - flush_i overrides start_i in IDLE.
- rst mid-operation: same as flush, plus all registers are cleared.
- op_i and operands are ignored outside IDLE; the latched copies are used.
- 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0 (wraparound).

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: for DIV/DIVU, when |dividend| < |divisor| (nonzero divisor), the block skips DIV and goes to FIX at t+1. Quotient 0, remainder = dividend after sign fix; done at t+2.
- Undefined: every nonzero-divisor DIV takes the full 34 cycles.
- Results are identical either way; only latency differs.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> done at t+2, result_o=0xFFFFFFFF_FFFFFFF1, whilo_o=11, stall_o high t..t+1, low at t+2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> done at t+34, result_o={0xFFFFFFFF, 0xFFFFFFFD}. DIVU with the same operands -> {0x00000001, 0x7FFFFFFC}.
- MADDU hi=0, lo=0xFFFFFFFF, a=1, b=1 -> done at t+3, result_o=0x00000001_00000000. MSUB hi=lo=0, a=1, b=1 -> 0xFFFFFFFF_FFFFFFFF.
- DIVU a=0x1234, b=0 -> done at t+2, result_o={0x00001234, 0xFFFFFFFF}.
- DIV in progress, flush_i at t+10 -> IDLE at t+11, no done_o/whilo_o ever; new MULT at t+12 completes normally.
- With MULDIV_EARLY_OUT_EN: DIVU a=3, b=10 -> done at t+2, result_o={3, 0}. Without the macro -> same result at t+34.
